// File: rtl/csa_mul_seq.sv
// Sequential unsigned multiplier built around a carry-save accumulator.
// One partial product is folded into a redundant sum/carry pair per cycle.
// A single carry-propagate add at the end resolves that pair into the product.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for an operand pair, in_ready high
//   ACC     | one 3:2 compression per edge, WIDTH edges in total
//   RESOLVE | out_p <= sum + carry
//   DONE    | product offered, held until out_ready
module csa_mul_seq #(
  parameter int WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACC     = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [PW-1:0]   sum_q;
  logic [PW-1:0]   carry_q;
  logic [CW-1:0]   cnt;

  logic [PW-1:0]   a_ext;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   maj;
  logic            last_step;

  // Partial product for the current multiplier bit and the carry-save majority
  always_comb begin
    a_ext     = {{WIDTH{1'b0}}, a_reg};
    pp        = b_reg[cnt] ? (a_ext << cnt) : '0;
    maj       = (sum_q & carry_q) | (sum_q & pp) | (carry_q & pp);
    last_step = (cnt == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = ACC;
      end
      ACC: begin
        if (last_step) state_nxt = RESOLVE;
      end
      RESOLVE: begin
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Return to IDLE only; the next accept needs a fresh IDLE cycle.
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, carry-save accumulation and final resolve
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      cnt     <= '0;
      out_p   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= in_a;
            b_reg   <= in_b;
            sum_q   <= '0;
            carry_q <= '0;
            cnt     <= '0;
          end
        end
        ACC: begin
          sum_q   <= sum_q ^ carry_q ^ pp;
          // Carry out of the MSB is dropped: the product is taken modulo 2^PW.
          carry_q <= {maj[PW-2:0], 1'b0};
          cnt     <= cnt + CW'(1);
        end
        RESOLVE: begin
          out_p <= sum_q + carry_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_mul_seq.sv
// Bench for csa_mul_seq: directed products with literal expectations, a
// stall, operand scrambling, asynchronous reset mid-operation and a random
// stream, all shadowed by a cycle-level behavioural model.
module tb_csa_mul_seq;

  localparam int W  = 12;
  localparam int PW = 2 * W;
  localparam int MIN_II = W + 3;
  localparam int DONE_AFTER = W + 1;  // edges after the accept edge until DONE

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_p;
  logic          busy;

  int tests = 0;
  int fails = 0;

  csa_mul_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an operation occupies the block from the accept edge,
  // the product appears DONE_AFTER edges later and stays until out_ready.
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  int            m_k = 0;
  logic [PW-1:0] m_exp = '0;
  logic [PW-1:0] m_last_p = '0;
  int            m_cyc = 0;
  int            m_prev_acc = -1;
  int            accept_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_k      = 0;
      m_last_p = '0;
      m_prev_acc = -1;
    end else begin
      m_cyc++;
      if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1'b1;
          m_k    = 0;
          m_exp  = {{W{1'b0}}, in_a} * {{W{1'b0}}, in_b};
          accept_cnt++;
          if (m_prev_acc >= 0) chk("initiation_interval_ok", longint'(m_cyc - m_prev_acc >= MIN_II), 1);
          m_prev_acc = m_cyc;
        end
      end else if (!m_done) begin
        m_k++;
        if (m_k == DONE_AFTER) begin
          m_done   = 1'b1;
          m_last_p = m_exp;
        end
      end else if (out_ready) begin
        m_busy = 1'b0;
        m_done = 1'b0;
      end
    end
  end

  // Compare every cycle away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready",  longint'(in_ready),  longint'(!m_busy));
      chk("busy",      longint'(busy),      longint'(m_busy));
      chk("out_valid", longint'(out_valid), longint'(m_done));
      chk("out_p",     longint'(out_p),     longint'(m_last_p));
    end
  end

  // One directed operation: measure latency, optional stall, optional scrambling
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input longint exp, input int stall, input bit scramble);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_before_accept", longint'(in_ready), 1);
    in_a = a; in_b = b; in_valid = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      if (scramble) begin
        in_a = W'($urandom);
        in_b = W'($urandom);
        in_valid = 1'b1;
      end
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    chk("latency_edges", n, 14);
    chk("product", longint'(out_p), exp);
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        chk("stall_valid", longint'(out_valid), 1);
        chk("stall_p", longint'(out_p), exp);
        chk("stall_in_ready", longint'(in_ready), 0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("ready_after_handshake", longint'(in_ready), 1);
    chk("p_held_after_done", longint'(out_p), exp);
    out_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    int target;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    #12;
    chk("reset_in_ready",  longint'(in_ready), 1);
    chk("reset_busy",      longint'(busy), 0);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_out_p",     longint'(out_p), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(12'd3328, 12'd3328, 64'd11075584, 0, 1'b0);
    run_op(12'd4095, 12'd4095, 64'd16769025, 0, 1'b0);
    run_op(12'd0,    12'd4095, 64'd0,        0, 1'b0);
    run_op(12'd1,    12'd4095, 64'd4095,     20, 1'b0);
    run_op(12'd100,  12'd200,  64'd20000,    0, 1'b1);
    run_op(12'd4095, 12'd1,    64'd4095,     3, 1'b1);

    // Asynchronous reset in the middle of accumulation
    in_a = 12'd777; in_b = 12'd555; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready",  longint'(in_ready), 1);
    chk("async_rst_busy",      longint'(busy), 0);
    chk("async_rst_out_valid", longint'(out_valid), 0);
    chk("async_rst_out_p",     longint'(out_p), 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(12'd2, 12'd3, 64'd6, 0, 1'b0);

    // Random stream with random back-pressure
    target = accept_cnt + 1000;
    cyc = 0;
    while (accept_cnt < target && cyc < 60000) begin
      in_valid  = ($urandom_range(3) != 0);
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      out_ready = $urandom_range(1) == 1;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while (busy && cyc < 60) begin
      @(posedge clk); #1; cyc++;
    end
    chk("stream_accepts", longint'(accept_cnt >= target), 1);
    chk("stream_drained", longint'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
